// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and hands words to decode.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_MISALIGN_EN.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_EN
   ,
   output logic        fetch_fault
`endif
);

   // state    | meaning
   // ST_FETCH | request to mem_addr=pc outstanding
   // ST_HOLD  | fetched word presented to decode, waiting for inst_ready
   // ST_DRAIN | squashed request outstanding, its data will be dropped
   // ST_IDLE  | parked after a misaligned redirect until reset
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_IDLE  = 2'd3
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] inst_nxt, inst_pc_nxt;
   logic        valid_nxt;
   logic        req_done;

`ifdef FETCH_MISALIGN_EN
   logic fault, fault_nxt;
   assign fetch_fault = fault;
`endif

   assign mem_req  = (state == ST_FETCH);
   assign mem_addr = pc;

   // Nothing left in flight once a redirect is taken: held word, or request acked this cycle.
   assign req_done = (state == ST_HOLD) || mem_ack;

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      inst_nxt    = inst;
      inst_pc_nxt = inst_pc;
      valid_nxt   = inst_valid;
`ifdef FETCH_MISALIGN_EN
      fault_nxt   = fault;
`endif
      case (state)
         ST_FETCH: begin
            if (mem_ack) begin
               inst_nxt    = mem_rdata;
               inst_pc_nxt = pc;
               valid_nxt   = 1'b1;
               state_nxt   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (inst_ready) begin
               valid_nxt = 1'b0;
               pc_nxt    = pc + 32'd4;
               state_nxt = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (mem_ack) begin
`ifdef FETCH_MISALIGN_EN
               state_nxt = fault ? ST_IDLE : ST_FETCH;
`else
               state_nxt = ST_FETCH;
`endif
            end
         end
         default: ;
      endcase

      if (redirect && (state != ST_IDLE)) begin
         inst_nxt    = inst;
         inst_pc_nxt = inst_pc;
         valid_nxt   = 1'b0;
         pc_nxt      = {redirect_pc[31:2], 2'b00};
         state_nxt   = req_done ? ST_FETCH : ST_DRAIN;
`ifdef FETCH_MISALIGN_EN
         if ((redirect_pc[1:0] != 2'b00) || fault) begin
            fault_nxt = 1'b1;
            state_nxt = req_done ? ST_IDLE : ST_DRAIN;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_FETCH;
         pc         <= RESET_PC;
         inst       <= NOP;
         inst_pc    <= 32'h0;
         inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
         fault      <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         inst       <= inst_nxt;
         inst_pc    <= inst_pc_nxt;
         inst_valid <= valid_nxt;
`ifdef FETCH_MISALIGN_EN
         fault      <= fault_nxt;
`endif
      end
   end

endmodule
